// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: per-channel H-bridge drive for the rover motors.
// One shared PWM counter feeds every channel. Each channel has its own
// STOP/RUN/DEAD/FAULT state machine. A DEAD interval keeps both bridge
// legs off before any stop or polarity reversal completes. A filtered
// overcurrent input forces a timed FAULT hold-off.
module motor_drive_ctrl #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned PERIOD   = 32768,
  parameter int unsigned DUTY1    = 23550,
  parameter int unsigned DUTY2    = 26555,
  parameter int unsigned DEADTIME = 2000,
  parameter int unsigned OC_FILT  = 16,
  parameter int unsigned OC_HOLD  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*N_CH-1:0] cmd_speed,
  input  logic [N_CH-1:0]   cmd_dir,
  input  logic [N_CH-1:0]   oc,
  output logic [N_CH-1:0]   pwm,
  output logic [N_CH-1:0]   fwd,
  output logic [N_CH-1:0]   rev,
  output logic [N_CH-1:0]   fault,
  output logic              pwm_wrap
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned DW = CW + 1;
  localparam int unsigned FW = $clog2(OC_FILT + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DUTY_C1   = DW'(DUTY1);
  localparam logic [DW-1:0] DUTY_C2   = DW'(DUTY2);
  localparam logic [DW-1:0] DUTY_FULL = DW'(PERIOD);
  localparam logic [FW-1:0] FILT_FULL = FW'(OC_FILT);
  localparam logic [31:0]   DEAD_LOAD = 32'(DEADTIME - 1);
  localparam logic [31:0]   HOLD_LOAD = 32'(OC_HOLD - 1);

  typedef enum logic [3:0] {
    ST_STOP  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DEAD  = 4'b0100,
    ST_FAULT = 4'b1000
  } state_e;

  // Speed code to high-cycle count; code 3 equals PERIOD so cnt < duty always holds.
  function automatic logic [DW-1:0] speed_to_duty(input logic [1:0] code);
    logic [DW-1:0] d;
    case (code)
      2'd1:    d = DUTY_C1;
      2'd2:    d = DUTY_C2;
      2'd3:    d = DUTY_FULL;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [FW-1:0]   filt_q  [N_CH];
  logic [FW-1:0]   filt_d  [N_CH];
  logic [N_CH-1:0] oc_det;
  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [N_CH-1:0] dir_q, dir_d;
  logic [DW-1:0]   duty_q  [N_CH];
  logic [DW-1:0]   duty_d  [N_CH];
  logic [31:0]     timer_q [N_CH];
  logic [31:0]     timer_d [N_CH];
  logic [N_CH-1:0] pwm_q, pwm_d;

  // Shared period counter and overcurrent synchroniser / saturating filter.
  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    sync1_d = oc;
    sync2_d = sync1_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!sync2_q[i]) begin
        filt_d[i] = '0;
      end else if (filt_q[i] != FILT_FULL) begin
        filt_d[i] = filt_q[i] + FW'(1);
      end else begin
        filt_d[i] = filt_q[i];
      end
      oc_det[i] = (filt_q[i] == FILT_FULL);
    end
  end

  // Per-channel state machine, duty reload and dead/fault timer.
  always_comb begin
    logic [1:0] spd;
    spd = '0;
    for (int i = 0; i < N_CH; i++) begin
      spd        = cmd_speed[2*i +: 2];
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      duty_d[i]  = duty_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_STOP: begin
          if (spd != 2'd0) begin
            state_d[i] = ST_RUN;
            dir_d[i]   = cmd_dir[i];
            duty_d[i]  = speed_to_duty(spd);
          end
        end
        ST_RUN: begin
          // Overcurrent outranks stop and reversal requests.
          if (oc_det[i]) begin
            state_d[i] = ST_FAULT;
            timer_d[i] = HOLD_LOAD;
          end else if ((spd == 2'd0) || (cmd_dir[i] != dir_q[i])) begin
            state_d[i] = ST_DEAD;
            timer_d[i] = DEAD_LOAD;
          end else if (wrap) begin
            // Reload only at period end so every RUN period is whole.
            duty_d[i] = speed_to_duty(spd);
          end
        end
        ST_DEAD: begin
          if (timer_q[i] == 32'd0) begin
            state_d[i] = ST_STOP;
          end else begin
            timer_d[i] = timer_q[i] - 32'd1;
          end
        end
        ST_FAULT: begin
          if (timer_q[i] != 32'd0) begin
            timer_d[i] = timer_q[i] - 32'd1;
          end else if (!oc_det[i]) begin
            state_d[i] = ST_STOP;
          end
        end
        default: state_d[i] = ST_STOP;
      endcase
      // The enable drops on the same edge the legs leave RUN, so the
      // bridge is never enabled while both legs are off.
      pwm_d[i] = (state_q[i] == ST_RUN) && (state_d[i] == ST_RUN) &&
                 ({1'b0, cnt_q} < duty_q[i]);
    end
  end

  // Leg and fault outputs decoded straight from the one-hot state register.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fwd[i]   = (state_q[i] == ST_RUN) &&  dir_q[i];
      rev[i]   = (state_q[i] == ST_RUN) && !dir_q[i];
      fault[i] = (state_q[i] == ST_FAULT);
    end
    pwm      = pwm_q;
    pwm_wrap = wrap;
  end

  // State registers; reset forces every channel to STOP with outputs low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      dir_q   <= '0;
      pwm_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_STOP;
        duty_q[i]  <= '0;
        timer_q[i] <= '0;
        filt_q[i]  <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        timer_q[i] <= timer_d[i];
        filt_q[i]  <= filt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: directed vector bench for motor_drive_ctrl with
// PERIOD=16, DUTY1=10, DUTY2=12, DEADTIME=4, OC_FILT=3, OC_HOLD=20.
`timescale 1ns/1ps
module tb_motor_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd_speed;
  logic [1:0] cmd_dir;
  logic [1:0] oc;
  logic [1:0] pwm, fwd, rev, fault;
  logic       pwm_wrap;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  typedef struct {
    int         cyc;
    logic [3:0] spd;
    logic [1:0] dir;
    logic [1:0] ocv;
    logic [1:0] e_pwm;
    logic [1:0] e_fwd;
    logic [1:0] e_rev;
    logic [1:0] e_flt;
    logic       e_wrap;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .N_CH(2), .PERIOD(16), .DUTY1(10), .DUTY2(12),
    .DEADTIME(4), .OC_FILT(3), .OC_HOLD(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
    .oc(oc), .pwm(pwm), .fwd(fwd), .rev(rev), .fault(fault),
    .pwm_wrap(pwm_wrap)
  );

  // Both legs of one channel must never be on together.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (fwd & rev) != 2'b00) overlap++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] e_pwm, input logic [1:0] e_fwd,
                          input logic [1:0] e_rev, input logic [1:0] e_flt, input logic e_wrap);
    chk({tag, "_pwm"},   32'(pwm),      32'(e_pwm));
    chk({tag, "_fwd"},   32'(fwd),      32'(e_fwd));
    chk({tag, "_rev"},   32'(rev),      32'(e_rev));
    chk({tag, "_fault"}, 32'(fault),    32'(e_flt));
    chk({tag, "_wrap"},  32'(pwm_wrap), 32'(e_wrap));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cmd_speed = vecs[i].spd;
      cmd_dir   = vecs[i].dir;
      oc        = vecs[i].ocv;
      tick(vecs[i].cyc);
      chk_outs($sformatf("row%0d", i), vecs[i].e_pwm, vecs[i].e_fwd,
               vecs[i].e_rev, vecs[i].e_flt, vecs[i].e_wrap);
    end
  endtask

  // Run n cycles counting pwm[0] highs and any ch1 activity.
  task automatic count_run(input int n, output int highs0, output int ch1_act);
    highs0  = 0;
    ch1_act = 0;
    for (int j = 0; j < n; j++) begin
      tick(1);
      if (pwm[0]) highs0++;
      if (pwm[1] | fwd[1] | rev[1] | fault[1]) ch1_act++;
    end
  endtask

  initial begin
    int h, a, n;
    logic e;

    // k = clock edges since reset release; cnt = k mod 16.
    //          cyc  spd      dir    oc     pwm    fwd    rev    flt    wrap
    vecs[0]  = '{1, 4'b0001, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0}; // k1 RUN, pwm not yet
    vecs[1]  = '{1, 4'b0001, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k2 first high
    vecs[2]  = '{8, 4'b0001, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k10 cnt9<10
    vecs[3]  = '{1, 4'b0001, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0}; // k11 cnt10
    vecs[4]  = '{4, 4'b0001, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1}; // k15 wrap
    vecs[5]  = '{2, 4'b0001, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k17
    vecs[6]  = '{10, 4'b0010, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0}; // k43 old duty kept
    vecs[7]  = '{4, 4'b0010, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1}; // k47 wrap
    vecs[8]  = '{12, 4'b0010, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k59 cnt10<12
    vecs[9]  = '{1, 4'b0010, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k60 cnt11
    vecs[10] = '{1, 4'b0010, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0}; // k61 cnt12
    vecs[11] = '{3, 4'b0011, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0}; // k80 last old period
    vecs[12] = '{1, 4'b0011, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}; // k81 full on
    vecs[13] = '{1, 4'b0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0}; // k98 DEAD
    vecs[14] = '{3, 4'b0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0}; // k101 DEAD end
    vecs[15] = '{1, 4'b0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0}; // k102 STOP
    vecs[16] = '{1, 4'b0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0}; // k103 RUN rev
    vecs[17] = '{1, 4'b0011, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0}; // k104 pwm on
    vecs[18] = '{1, 4'b0111, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 1'b0}; // k105 ch1 RUN fwd

    rst_n     = 1'b0;
    cmd_speed = '0;
    cmd_dir   = '0;
    oc        = '0;
    tick(3);
    chk_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;

    // Speed 1 forward on ch0.
    run_rows(0, 5);
    count_run(16, h, a);
    chk("duty1_highs", 32'(h), 32'd10);
    chk("duty1_ch1_idle", 32'(a), 32'd0);

    // Speed 1 -> 2 mid-period.
    run_rows(6, 10);
    count_run(16, h, a);
    chk("duty2_highs", 32'(h), 32'd12);

    // Speed 3: constant high after the next wrap.
    run_rows(11, 12);
    count_run(16, h, a);
    chk("full_highs", 32'(h), 32'd16);
    chk("full_ch1_idle", 32'(a), 32'd0);

    // Reversal with dead-time, then start ch1.
    run_rows(13, 18);

    // ch1 oc: 2 high, 1 low, then held high until k139.
    for (int k = 105; k <= 145; k++) begin
      oc = (k == 105 || k == 106 || (k >= 108 && k <= 139)) ? 2'b10 : 2'b00;
      tick(1);
      n = k + 1;
      e = (n >= 114 && n <= 143);
      chk($sformatf("oc_fault_k%0d", n), 32'(fault), 32'({e, 1'b0}));
      if (n == 114) begin
        chk("fault_entry_fwd1", 32'(fwd[1]), 32'd0);
        chk("fault_entry_pwm1", 32'(pwm[1]), 32'd0);
        chk("fault_ch0_rev", 32'(rev[0]), 32'd1);
        chk("fault_ch0_pwm", 32'(pwm[0]), 32'd1);
      end
      if (n == 144) chk("fault_exit_stop", 32'({fwd[1], rev[1]}), 32'd0);
      if (n == 145) chk("fault_exit_run", 32'(fwd[1]), 32'd1);
    end
    chk("restart_pwm1", 32'(pwm[1]), 32'd1);

    // ch1 back into FAULT, ch0 into DEAD, then asynchronous reset.
    for (int k = 146; k <= 151; k++) begin
      oc = 2'b10;
      tick(1);
    end
    chk("refault", 32'(fault), 32'b10);
    cmd_speed = 4'b0100;
    tick(2);
    chk("dead_ch0_legs", 32'({pwm[0], fwd[0], rev[0]}), 32'd0);
    chk("dead_ch1_fault", 32'(fault), 32'b10);
    rst_n = 1'b0;
    #1;
    chk_outs("rst_async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    cmd_speed = 4'b0101;
    cmd_dir   = 2'b11;
    oc        = 2'b00;
    tick(2);
    chk_outs("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk_outs("rel_k1", 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
    tick(1);
    chk_outs("rel_k2", 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

    // 5-cycle oc burst on ch1: FAULT held for exactly OC_HOLD cycles.
    for (int k = 2; k <= 28; k++) begin
      oc = (k >= 2 && k <= 6) ? 2'b10 : 2'b00;
      tick(1);
      n = k + 1;
      e = (n >= 8 && n <= 27);
      chk($sformatf("hold_fault_k%0d", n), 32'(fault[1]), 32'(e));
      if (n == 28) chk("hold_stop_fwd1", 32'(fwd[1]), 32'd0);
      if (n == 29) chk("hold_run_fwd1", 32'(fwd[1]), 32'd1);
    end
    chk("hold_ch0_fwd", 32'(fwd[0]), 32'd1);
    chk("leg_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Parametrised per-side motor drive controller for the line-following rover. It sits between the sensor-decode logic, which issues a speed code and direction per side, and the H-bridge pins. It generates glitch-free PWM from one shared counter and inserts dead-time before any polarity reversal. Each channel also has its own filtered overcurrent shutdown with a timed hold-off, a feature the current drive path lacks.

## Interface
Parameters:
- N_CH, 2, number of motor channels (0 = right, 1 = left)
- PERIOD, 32768, PWM period in clk cycles; CW = $clog2(PERIOD)
- DUTY1, 23550, high-cycle count for speed code 1 (must be < PERIOD)
- DUTY2, 26555, high-cycle count for speed code 2 (must be < PERIOD)
- DEADTIME, 2000, cycles with both bridge legs off before a direction change or stop completes
- OC_FILT, 16, consecutive synchronised-high samples needed to declare overcurrent
- OC_HOLD, 1000000, minimum cycles spent in FAULT

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_speed  in  2*N_CH  per-channel speed code, bits [2i+1:2i]; 0 stop, 1 DUTY1, 2 DUTY2, 3 full on
- cmd_dir  in  N_CH  per-channel direction, 1 forward, 0 reverse
- oc  in  N_CH  asynchronous comparator outputs, high = overcurrent
- pwm  out  N_CH  bridge enable (PWM)
- fwd  out  N_CH  forward polarity leg
- rev  out  N_CH  reverse polarity leg
- fault  out  N_CH  channel is in FAULT
- pwm_wrap  out  1  one-cycle pulse on the cycle cnt == PERIOD-1

## Operation
- Shared counter cnt[CW-1:0] counts 0..PERIOD-1 and wraps to 0.
- Each channel has a duty register duty_act[CW:0]. Speed codes map as 0→0, 1→DUTY1, 2→DUTY2, 3→PERIOD (always high).
- Each channel has a one-hot FSM with states STOP, RUN, DEAD, FAULT. Reset state is STOP.
- STOP: fwd = rev = pwm = 0. If cmd_speed ≠ 0, the FSM latches dir_q = cmd_dir, loads duty_act immediately, and moves to RUN on the next cycle.
- RUN: fwd = dir_q, rev = ~dir_q. duty_act reloads from cmd_speed only on pwm_wrap cycles. Exit priority, evaluated every cycle:
  - (1) oc_det → FAULT
  - (2) cmd_speed == 0 → DEAD
  - (3) cmd_dir ≠ dir_q → DEAD
- DEAD: fwd = rev = pwm = 0. The timer loads DEADTIME-1 on entry and decrements each cycle. At timer == 0 the FSM moves to STOP, which then re-evaluates the command.
- FAULT: fwd = rev = pwm = 0, fault = 1. The timer loads OC_HOLD-1 on entry and decrements to 0, then holds. The FSM exits to STOP only when timer == 0 and oc_det == 0.
- The DEAD and FAULT timers are one per channel, each 32 bits wide, shared between the two states.
- Overcurrent path, per channel:
  - oc passes through a 2-flop synchroniser.
  - A saturating counter increments while the synchronised signal is high and clears to 0 when it is low.
  - oc_det = (counter == OC_FILT).
- fwd and rev are never both 1. Any change of fwd/rev value is always preceded by at least DEADTIME cycles with both at 0.
- Channels are fully independent except for sharing cnt.

## Timing
- Reset: all outputs 0, cnt = 0, every FSM in STOP, all timers, filters and synchronisers 0.
- Reset asserted mid-operation drops every output to 0 asynchronously. No dead-time is honoured on reset.
- pwm is registered: pwm[i] ← (state == RUN) && (cnt < duty_act), so it lags cnt by one cycle. fwd, rev and fault are decoded directly from the state register.
- Start from STOP: command at cycle t gives state RUN at t+1 and first pwm high at t+2 (when cnt < duty).
- Direction change or stop request at cycle t: DEAD from t+1 to t+DEADTIME, STOP at t+DEADTIME+1, RUN at t+DEADTIME+2.
- Overcurrent: oc rising before edge e gives oc_det at edge e+OC_FILT+1 and FAULT on the following edge. A single-cycle low on the synchronised signal restarts the filter.
- A duty change during RUN takes effect at the first pwm_wrap after the change. There are no partial or runt periods except on entry to RUN.
- Simultaneous oc_det and a stop or direction change: FAULT wins.
- cmd_speed = 0 during FAULT or DEAD has no effect on timing.

## Test plan
Parameters for all cases: N_CH=2, PERIOD=16, DUTY1=10, DUTY2=12, DEADTIME=4, OC_FILT=3, OC_HOLD=20.

- Reset, then ch0 speed 1 forward → fwd[0]=1, rev[0]=0, pwm[0] high 10 of every 16 cycles; code 3 → pwm[0] constant 1; ch1 outputs stay 0.
- ch0 RUN forward, speed changed 1→2 mid-period → pwm[0] keeps 10-cycle highs until pwm_wrap, then 12-cycle highs.
- ch0 RUN forward, cmd_dir→0 at t → fwd/rev/pwm 0 for cycles t+1..t+4, rev[0]=1 from t+6; fwd and rev never simultaneously 1.
- ch1 oc high 2 cycles, low 1, high 5 → first burst ignored; FAULT entered after second burst; fault[1]=1; ch0 unaffected.
- ch1 in FAULT with oc held high beyond 20 cycles → stays in FAULT; oc low → STOP after filter clears, then RUN if speed ≠ 0.
- rst_n pulsed low while ch0 in DEAD and ch1 in FAULT → all outputs 0 immediately; both FSMs in STOP after release.
